// File: rtl/shift2_reg_ctrl.sv
// Sequencer for the 2-bit-per-nucleotide database shift register: fetches words into a
// one-word prefetch buffer and slides the 512b window one nucleotide per downstream accept.
module shift2_reg_ctrl #(
   parameter int DATA_W       = 512,
   parameter int ADDR_W       = 32,
   parameter int CNT_W        = 16,
   parameter int POS_W        = 24,
   parameter int PRIME_SHIFTS = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  num_words,
   output logic              busy,
   output logic              done,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_valid,
   input  logic [DATA_W-1:0] mem_data,
   output logic              sr_load,
   output logic              sr_shift,
   output logic [DATA_W-1:0] sr_data,
   output logic              win_valid,
   input  logic              win_ready,
   output logic [POS_W-1:0]  win_pos,
   output logic [2:0]        dbg_state
);

   localparam int WORD_NT = DATA_W / 2;
   localparam int NT_B    = $clog2(WORD_NT);
   localparam int PC_W    = $clog2(PRIME_SHIFTS + 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH0 = 3'd1,
      S_LOAD0  = 3'd2,
      S_PRIME  = 3'd3,
      S_RUN    = 3'd4,
      S_FIN    = 3'd5
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    num_q, num_d;
   logic [CNT_W-1:0]    req_idx_q, req_idx_d;
   logic                pend_q, pend_d;
   logic                full_q, full_d;
   logic [DATA_W-1:0]   buf_q, buf_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [POS_W-1:0]    pos_q, pos_d;
   logic [PC_W-1:0]     prime_q, prime_d;

   logic                req_ok;
   logic                take;
   logic                boundary;
   logic                is_final;
   logic [CNT_W-1:0]    word_last;
   logic [POS_W-1:0]    final_pos;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         num_q     <= '0;
         req_idx_q <= '0;
         pend_q    <= 1'b0;
         full_q    <= 1'b0;
         buf_q     <= '0;
         addr_q    <= '0;
         pos_q     <= '0;
         prime_q   <= '0;
      end else begin
         state_q   <= state_d;
         num_q     <= num_d;
         req_idx_q <= req_idx_d;
         pend_q    <= pend_d;
         full_q    <= full_d;
         buf_q     <= buf_d;
         addr_q    <= addr_d;
         pos_q     <= pos_d;
         prime_q   <= prime_d;
      end
   end

   // Window handshake: win_valid/win_pos are stable until win_valid & win_ready is seen at a
   // rising edge; win_valid only drops without an accept when the next word is not buffered yet.
   always_comb begin
      state_d   = state_q;
      num_d     = num_q;
      req_idx_d = req_idx_q;
      pend_d    = pend_q;
      full_d    = full_q;
      buf_d     = buf_q;
      addr_d    = addr_q;
      pos_d     = pos_q;
      prime_d   = prime_q;
      sr_load   = 1'b0;
      sr_shift  = 1'b0;
      win_valid = 1'b0;
      done      = 1'b0;

      word_last = num_q - CNT_W'(1);
      final_pos = POS_W'({word_last, {NT_B{1'b0}}});
      boundary  = &pos_q[NT_B-1:0];
      is_final  = (pos_q == final_pos);

      // Single outstanding read; the address register advances when its data lands.
      req_ok = (state_q inside {S_FETCH0, S_PRIME, S_RUN}) && !full_q && !pend_q &&
               (req_idx_q < num_q);
      take   = mem_valid && pend_q && (state_q != S_IDLE);
      if (req_ok) begin
         pend_d    = 1'b1;
         req_idx_d = req_idx_q + CNT_W'(1);
      end
      if (take) begin
         buf_d  = mem_data;
         full_d = 1'b1;
         pend_d = 1'b0;
         addr_d = addr_q + ADDR_W'(1);
      end

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               num_d     = num_words;
               addr_d    = base_addr;
               req_idx_d = '0;
               pos_d     = '0;
               pend_d    = 1'b0;
               full_d    = 1'b0;
               state_d   = (num_words == '0) ? S_FIN : S_FETCH0;
            end
         end
         S_FETCH0: begin
            if (full_q) state_d = S_LOAD0;
         end
         S_LOAD0: begin
            sr_load = 1'b1;
            full_d  = 1'b0;
            prime_d = '0;
            state_d = S_PRIME;
         end
         S_PRIME: begin
            sr_shift = 1'b1;
            prime_d  = prime_q + PC_W'(1);
            if (prime_q == PC_W'(PRIME_SHIFTS - 1)) state_d = S_RUN;
         end
         S_RUN: begin
            win_valid = !(boundary && !full_q);
            if (win_valid && win_ready) begin
               if (is_final) begin
                  state_d = S_FIN;
               end else begin
                  sr_shift = 1'b1;
                  pos_d    = pos_q + POS_W'(1);
                  if (boundary) begin
                     sr_load = 1'b1;
                     full_d  = 1'b0;
                  end
               end
            end
         end
         S_FIN: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy      = (state_q != S_IDLE);
   assign mem_req   = req_ok;
   assign mem_addr  = addr_q;
   assign sr_data   = buf_q;
   assign win_pos   = pos_q;
   assign dbg_state = state_q;

endmodule
